// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC owner, single-outstanding imem requester, one-entry decoded output buffer.
// Define FETCH_PERF_CNT_EN to add fetchCount_o / bubbleCount_o performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirectPC_i,
  output logic        imemReq_o,
  output logic [31:0] imemAddr_o,
  input  logic        imemAck_i,
  input  logic [31:0] imemData_i,
  output logic        valid_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic [24:0] Instr31_7_o,
  output logic [31:0] PC_o,
  output logic [31:0] pcPlus4_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount_o,
  output logic [31:0] bubbleCount_o
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] bufPc_q, bufPc_d;
  logic [31:0] bufPc4_q, bufPc4_d;
  logic        bufFree, consume;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      bufPc_q  <= '0;
      bufPc4_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      bufPc_q  <= bufPc_d;
      bufPc4_q <= bufPc4_d;
    end
  end

  always_comb begin
    // Requests only go out when the buffer will have room for the answer,
    // so an ack never lands on a live entry.
    bufFree   = !valid_q || !stall_i;
    imemReq_o = (state_q == S_FETCH) && bufFree && !redirect_i && !rst_i;
    consume   = valid_q && !stall_i && !redirect_i;

    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q && !consume;
    instr_d  = instr_q;
    bufPc_d  = bufPc_q;
    bufPc4_d = bufPc4_q;

    if (redirect_i) begin
      // Redirect wins over stall and ack; an in-flight response must be dropped.
      pc_d    = redirectPC_i;
      valid_d = 1'b0;
      if (state_q == S_WAIT)
        state_d = imemAck_i ? S_FETCH : S_DROP;
    end else begin
      case (state_q)
        S_FETCH: if (imemReq_o) state_d = S_WAIT;
        S_WAIT: begin
          if (imemAck_i) begin
            instr_d  = imemData_i;
            bufPc_d  = pc_q;
            bufPc4_d = pc_q + 32'd4;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            state_d  = S_FETCH;
          end
        end
        S_DROP:  if (imemAck_i) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign imemAddr_o  = pc_q;
  assign valid_o     = valid_q;
  assign rs1_o       = instr_q[19:15];
  assign rs2_o       = instr_q[24:20];
  assign rd_o        = instr_q[11:7];
  assign op_o        = instr_q[6:0];
  assign funct3_o    = instr_q[14:12];
  assign Instr31_7_o = instr_q[31:7];
  assign PC_o        = bufPc_q;
  assign pcPlus4_o   = bufPc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt_q, bubbleCnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetchCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      if (consume) fetchCnt_q  <= fetchCnt_q + 32'd1;
      if (!valid_q) bubbleCnt_q <= bubbleCnt_q + 32'd1;
    end
  end

  assign fetchCount_o  = fetchCnt_q;
  assign bubbleCount_o = bubbleCnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the PC, issues single-outstanding requests to instruction memory and presents decoded instruction fields to the IF/ID pipeline register. It sits between instruction memory and IF/ID. It absorbs decode-stage stalls with a one-entry output buffer and handles execute-stage redirects by flushing the buffer and discarding any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  decode cannot accept; hold output buffer.
- redirect_i  in  1  branch/jump taken; flush and restart fetch.
- redirectPC_i  in  32  new fetch address when redirect_i=1.
- imemReq_o  out  1  request strobe, one cycle per request.
- imemAddr_o  out  32  request address (current PC).
- imemAck_i  in  1  response valid; arrives ≥1 cycle after request.
- imemData_i  in  32  instruction word, valid with imemAck_i.
- valid_o  out  1  output buffer holds a live instruction.
- rs1_o / rs2_o / rd_o  out  5  instr[19:15] / [24:20] / [11:7].
- op_o  out  7  instr[6:0].
- funct3_o  out  3  instr[14:12].
- Instr31_7_o  out  25  instr[31:7].
- PC_o  out  32  address of the buffered instruction.
- pcPlus4_o  out  32  PC_o + 4 (mod 2^32).

## Operation
- Registers: pc[31:0], state {FETCH, WAIT, DROP}, output buffer (valid_o plus all field outputs).
- bufFree = !valid_o || !stall_i (empty, or consumed this cycle).
- imemReq_o = (state==FETCH) && bufFree && !redirect_i && !rst_i. imemAddr_o = pc at all times.
- FETCH: request issued → WAIT. No request → stay FETCH. Any imemAck_i arriving in FETCH is ignored.
- WAIT, imemAck_i=1, no redirect:
  - Load the buffer: fields decoded from imemData_i, PC_o=pc, pcPlus4_o=pc+4, valid_o=1.
  - pc ← pc+4; → FETCH.
- WAIT, imemAck_i=0: hold.
- DROP: imemAck_i=1 → data discarded, → FETCH. Otherwise hold.
- The buffer is always empty when an ack lands, because a request is only issued when bufFree.
- Consumption: buffer is consumed when valid_o && !stall_i && !redirect_i. Consumed and not refilled in the same cycle → valid_o ← 0.
- Redirect (priority over stall and ack):
  - pc ← redirectPC_i; valid_o ← 0.
  - FETCH: stay FETCH, no request that cycle.
  - WAIT with no ack: → DROP.
  - WAIT with ack: data discarded, → FETCH.
  - DROP: stay DROP with updated pc.
- Stall with valid_o=1: buffer and field outputs held bit-exact.
- PC arithmetic wraps modulo 2^32. redirectPC_i is not masked or checked.

## Timing
- Reset (async, immediate) values:
  - pc=RESET_PC, state=FETCH.
  - valid_o=0; all field outputs 0 (PC_o=0, pcPlus4_o=0).
  - imemReq_o=0 while rst_i=1.
- First request appears in the first cycle after rst_i deasserts.
- Memory with 1-cycle latency:
  - Request in cycle N, ack in N+1.
  - valid_o=1 from N+2; next request in N+2 if bufFree.
  - Steady-state throughput: 1 instruction per 2 cycles.
- Reset mid-operation aborts WAIT/DROP. Instruction memory is reset by the same rst_i; stale acks after reset fall into FETCH and are ignored.
- All outputs except imemReq_o are registered. imemReq_o is combinational from state, valid_o, stall_i, redirect_i and rst_i.

## Configuration
- FETCH_PERF_CNT_EN defined adds two outputs, both reset to 0 and wrapping at 2^32:
  - fetchCount_o[31:0]: +1 each cycle an instruction is consumed.
  - bubbleCount_o[31:0]: +1 each cycle with valid_o=0 and rst_i=0.
- FETCH_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory returning 0x00A28293 (addi x5,x5,10) → first imemAddr_o=0x100. valid_o=1 two cycles later with rs1_o=5, rd_o=5, op_o=0x13, funct3_o=0, PC_o=0x100, pcPlus4_o=0x104. Next request at 0x104.
- Hold stall_i=1 for 5 cycles with valid_o=1 → outputs unchanged, imemReq_o=0 throughout. Release stall → request at next PC in the same cycle.
- Redirect to 0x2000 while in WAIT; ack arrives 3 cycles later with 0xDEADBEEF → response discarded, valid_o stays 0, next request at 0x2000.
- Redirect and ack in the same WAIT cycle → data discarded, next request at redirectPC_i in the following cycle, valid_o=0.
- pc=0xFFFF_FFFC fetch → pcPlus4_o=0x0, next request at 0x0.
- With FETCH_PERF_CNT_EN: 10 instructions, no stalls, 1-cycle memory → fetchCount_o=10. bubbleCount_o counts the non-valid cycles, 11 at the 10th consumption. Assert rst_i mid-run → both counters 0 immediately.
